imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory's write port. It accepts a byte stream from the UART receiver over a valid/ready handshake and packs it into 32-bit little-endian words. It then issues word writes at byte addresses 0, 4, 8, … and holds the core stalled until the whole image is written. It sits between the UART RX block and the instruction memory's `w_en`/`write_addr`/`write_data` inputs.

## Interface
- `INST_MEMORY_SIZE`, 1024: instruction memory size in bytes; must match the instruction memory.
- `ADDR_WIDTH`, `$clog2(INST_MEMORY_SIZE)`: byte-address width.
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; only sampled in IDLE.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `w_en` out 1: instruction memory write strobe; one cycle per word.
- `write_addr` out ADDR_WIDTH: byte address of the word; always a multiple of 4.
- `write_data` out 32: packed word; byte 0 of the group is `[7:0]`.
- `busy` out 1: load in progress; drives the core stall/hold.
- `done` out 1: one-cycle pulse when a load completes successfully.
- `err` out 1: sticky length error; cleared by the next accepted `start` or by reset.

## Operation
- States: IDLE, LEN, DATA, FLUSH, DONE, ERR.
- IDLE
  - `rx_ready`=0 and `busy`=0.
  - `start`=1 → LEN; clears `err`, the byte counter and the word address.
- LEN
  - `rx_ready`=1; receives 4 bytes, little-endian, forming `len_words` (32 bit).
  - If `len_words`==0 → DONE.
  - Else if `len_words` > `INST_MEMORY_SIZE/4` (compared at 32-bit width) → ERR.
  - Else → DATA.
- DATA
  - `rx_ready`=1. A byte transfers when `rx_valid && rx_ready`.
  - Bytes shift into a 4-byte packer.
  - On the 4th byte, the packed word and current address are registered and `w_en` pulses the next cycle.
  - Address increments by 4 after each write; the word counter decrements.
  - After the 4th byte of the last word → FLUSH, with `rx_ready`=0 from that cycle.
- FLUSH
  - Final `w_en` cycle → DONE.
- DONE
  - `done`=1 for one cycle → IDLE. `busy` falls in the same cycle as the IDLE entry.
- ERR
  - `err`=1 and `busy`=0.
  - No writes are ever issued for a rejected length.
  - → IDLE on the next cycle; `err` stays high until the next `start`.
- Handshake rules
  - `rx_ready` depends only on state, never on `rx_valid`.
  - Bytes offered in IDLE/FLUSH/DONE/ERR are not consumed.
- Boundary cases
  - `start` in any state other than IDLE is ignored.
  - Maximum image (`INST_MEMORY_SIZE/4` words) ends at address `INST_MEMORY_SIZE-4`; the address never wraps.
  - Reset mid-load: next cycle is IDLE; the partial word is discarded and no `w_en` is emitted. Memory contents already written are left as-is.
- Reset values: `rx_ready`=0, `w_en`=0, `write_addr`=0, `write_data`=0, `busy`=0, `done`=0, `err`=0.

## Timing
- `busy` rises the cycle after `start` is accepted.
- A write lags the accepting edge of its 4th byte by one cycle: byte accepted at edge k, `w_en`=1 during cycle k+1.
- Back-to-back bytes sustain one word per 4 cycles; `w_en` is never high on two consecutive cycles.
- `write_addr`/`write_data` are valid only while `w_en`=1. They hold their last values otherwise.
- A load of N>0 words takes 4 + 4N accepted bytes plus 2 cycles (FLUSH, DONE) after the last byte.

## Structure
- Package `imem_loader_pkg`:
  - state enum (`S_IDLE`, `S_LEN`, `S_DATA`, `S_FLUSH`, `S_DONE`, `S_ERR`);
  - `BYTES_PER_WORD`=4;
  - 2-bit byte-index type.
- Sub-module `byte_packer`:
  - 2-bit byte index, 32-bit shift register with little-endian placement;
  - `word_valid` pulse on the 4th byte;
  - `clear` input;
  - shared by the LEN and DATA phases.

## Test plan
- Reset, then stream length 2 and words 0x00000013, 0x00100093 → writes (0x000, 0x00000013) and (0x004, 0x00100093); `done` pulses once; `busy` drops.
- Length 0 → no `w_en`; `done` 1 cycle after the 4th length byte.
- Length 257 with the default size → `err`=1, no `w_en`, `rx_ready`=0. A following `start` clears `err`.
- Length 256 → last write at `write_addr`=0x3FC; no wrap.
- `rx_valid` toggled randomly and `start` pulsed during DATA → identical writes; `start` ignored.
- `rst_n`=0 after 2 bytes of word 1 → next cycle all outputs at reset values; no `w_en`. A fresh load afterwards writes from address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// State encoding, word geometry and the packer byte index.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer shared by the length and data phases.
// Ports: clk/rst_n, clear_i, valid_i+byte_i in; word_o+word_valid_o out.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  byte_idx_t   idx_q;
  logic [23:0] sh_q;

  // The 4th byte is not stored; it is combined
  // directly so the word is usable on its edge.
  assign word_o       = {byte_i, sh_q};
  assign word_valid_o = valid_i && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
    end else if (valid_i) begin
      idx_q <= idx_q + 2'd1;
      sh_q  <= {byte_i, sh_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: UART byte stream -> instruction memory word writes.
// Ports: start, rx_* handshake in; w_en/write_*, busy, done, err out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INST_MEMORY_SIZE = 1024,
  parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] MAX_WORDS =
    32'(INST_MEMORY_SIZE / BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q;
  logic                  wen_q;
  logic                  err_q;

  logic        fire;
  logic        go;
  logic [31:0] word;
  logic        word_v;

  assign fire = rx_valid && rx_ready;
  assign go   = (state_q == S_IDLE) && start;

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (go),
    .valid_i      (fire),
    .byte_i       (rx_data),
    .word_o       (word),
    .word_valid_o (word_v)
  );

  assign w_en       = wen_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign err        = err_q;

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (word_v) begin
          if (word == '0)
            state_d = S_DONE;
          else if (word > MAX_WORDS)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (word_v && cnt_q == ONE)
          state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= 1'b0;
      if (go) begin
        err_q  <= 1'b0;
        addr_q <= '0;
      end
      // Oversized lengths truncate here but go to ERR.
      if (state_q == S_LEN && word_v)
        cnt_q <= word[ADDR_WIDTH-1:0];
      if (state_q == S_DATA && word_v) begin
        wen_q   <= 1'b1;
        waddr_q <= addr_q;
        wdata_q <= word;
        addr_q  <= addr_q + STEP;
        cnt_q   <= cnt_q - ONE;
      end
      if (state_d == S_ERR)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// Byte-count reference model plus literal pins.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        w_en;
  logic [9:0]  write_addr;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.INST_MEMORY_SIZE(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .w_en       (w_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          act = 1'b0;
  int          tail = 0;
  bit          in_err = 1'b0;
  longint      cnt = 0;
  logic [31:0] len = '0;
  logic [31:0] cur = '0;
  bit          m_err = 1'b0;
  bit          e_rdy = 1'b0;
  bit          e_wen = 1'b0;
  bit          e_busy = 1'b0;
  bit          e_done = 1'b0;
  logic [9:0]  e_addr = '0;
  logic [31:0] e_data = '0;
  logic [7:0]  stream[$];
  int          lg_addr[$];
  logic [31:0] lg_data[$];
  int          ndone = 0;

  // stimulus knobs
  int          vprob = 100;
  bit          rstart_en = 1'b0;
  logic [31:0] wq[$];

  always @(posedge clk) begin
    bit idle;
    bit acc;
    int pos;
    longint w;
    if (!rst_n) begin
      act = 0; tail = 0; in_err = 0; cnt = 0;
      m_err = 0; e_wen = 0; e_addr = '0; e_data = '0;
      stream.delete();
    end else begin
      idle = !act && tail == 0 && !in_err;
      acc = e_rdy && rx_valid;
      e_wen = 0;
      in_err = 0;
      if (tail > 0) tail--;
      if (idle && start) begin
        act = 1; cnt = 0; m_err = 0;
      end else if (acc) begin
        pos = int'(cnt % 4);
        if (pos == 0) cur = '0;
        cur = cur | (32'(rx_data) << (8 * pos));
        cnt++;
        if (stream.size() > 0) void'(stream.pop_front());
        if (cnt == 4) begin
          len = cur;
          if (len == 0) begin
            act = 0; tail = 1;
          end else if (len > 256) begin
            act = 0; m_err = 1; in_err = 1;
          end
        end else if (cnt % 4 == 0) begin
          w = (cnt - 4) / 4;
          e_wen = 1;
          e_addr = 10'(4 * (w - 1));
          e_data = cur;
          lg_addr.push_back(int'(e_addr));
          lg_data.push_back(cur);
          if (w == longint'(len)) begin
            act = 0; tail = 2;
          end
        end
      end
      if (tail == 1) ndone++;
    end
    e_rdy = act && (cnt < 4 || cnt < 4 + 4 * longint'(len));
    e_busy = act || tail > 0;
    e_done = (tail == 1);
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("rx_ready", 32'(rx_ready), 32'(e_rdy));
    check("w_en", 32'(w_en), 32'(e_wen));
    check("write_addr", 32'(write_addr), 32'(e_addr));
    check("write_data", write_data, e_data);
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(m_err));
  end

  task automatic cycle(input bit st);
    @(negedge clk);
    rx_valid = ($urandom_range(99) < vprob);
    rx_data = (stream.size() > 0) ? stream[0] : 8'($urandom);
    start = st || (rstart_en && act && ($urandom_range(15) == 0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((act || tail != 0 || in_err) && n < 20000) begin
      cycle(0);
      n++;
    end
    if (act || tail != 0 || in_err) begin
      miscompares++;
      $display("FAIL wait_idle timeout t=%0t", $time);
    end
  endtask

  task automatic push_len(input logic [31:0] l, input int n);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) stream.push_back(l[8*i +: 8]);
    for (int i = 0; i < n; i++) begin
      v = wq[i];
      for (int j = 0; j < 4; j++) stream.push_back(v[8*j +: 8]);
    end
  endtask

  task automatic do_load(input logic [31:0] l, input int n);
    wait_idle();
    push_len(l, n);
    cycle(1);
    cycle(0);
    wait_idle();
  endtask

  task automatic clr_log();
    lg_addr.delete();
    lg_data.delete();
    ndone = 0;
  endtask

  initial begin
    int n;
    logic [31:0] l;
    rst_n = 1'b0;
    repeat (3) cycle(0);
    rst_n = 1'b1;
    repeat (2) cycle(0);

    // two-word image
    clr_log();
    wq = '{32'h0000_0013, 32'h0010_0093};
    do_load(32'd2, 2);
    check("pin_nwr2", 32'(lg_addr.size()), 32'd2);
    check("pin_a0", 32'(lg_addr[0]), 32'h000);
    check("pin_d0", lg_data[0], 32'h0000_0013);
    check("pin_a1", 32'(lg_addr[1]), 32'h004);
    check("pin_d1", lg_data[1], 32'h0010_0093);
    check("pin_done2", 32'(ndone), 32'd1);

    // zero length
    clr_log();
    do_load(32'd0, 0);
    check("pin_nwr0", 32'(lg_addr.size()), 32'd0);
    check("pin_done0", 32'(ndone), 32'd1);

    // one word over the limit
    clr_log();
    do_load(32'd257, 0);
    repeat (3) cycle(0);
    check("pin_err257", 32'(m_err), 32'd1);
    check("pin_nwr257", 32'(lg_addr.size()), 32'd0);
    check("pin_done257", 32'(ndone), 32'd0);
    clr_log();
    wq = '{32'h1234_5678};
    do_load(32'd1, 1);
    check("pin_errclr", 32'(m_err), 32'd0);

    // full memory, bursty valid
    clr_log();
    vprob = 70;
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    do_load(32'd256, 256);
    check("pin_nwr256", 32'(lg_addr.size()), 32'd256);
    check("pin_last", 32'(lg_addr[255]), 32'h3FC);

    // random loads, random valid, stray starts
    vprob = 50;
    rstart_en = 1'b1;
    repeat (12) begin
      if ($urandom_range(3) == 0) begin
        l = 32'd257 + 32'($urandom_range(100000));
        do_load(l, 0);
      end else begin
        n = $urandom_range(8, 1);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
        do_load(32'(n), n);
      end
      repeat ($urandom_range(3)) cycle(0);
    end
    rstart_en = 1'b0;

    // reset after two bytes of the first word
    wait_idle();
    clr_log();
    vprob = 100;
    wq = '{32'h1111_1111, 32'h2222_2222};
    push_len(32'd2, 2);
    cycle(1);
    cycle(0);
    n = 0;
    while (cnt < 6 && n < 100) begin
      cycle(0);
      n++;
    end
    rst_n = 1'b0;
    cycle(0);
    rst_n = 1'b1;
    repeat (2) cycle(0);
    check("pin_nwr_rst", 32'(lg_addr.size()), 32'd0);
    clr_log();
    wq = '{32'hCAFE_F00D};
    do_load(32'd1, 1);
    check("pin_rst_a0", 32'(lg_addr[0]), 32'h000);
    check("pin_rst_d0", lg_data[0], 32'hCAFE_F00D);

    repeat (4) cycle(0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
